// File: rtl/fir_mac_seq_if.sv
// Sample-stream and coefficient-write bundle for fir_mac_seq.
// The master drives samples and coefficient writes; the slave returns busy/ordy/dout.
interface fir_mac_seq_if #(
    parameter int DW   = 10,
    parameter int CW   = 12,
    parameter int TAPS = 4
) ();
    localparam int IW = $clog2(TAPS);

    logic                 irdy;
    logic signed [DW-1:0] din;
    logic                 cwe;
    logic [IW-1:0]        caddr;
    logic signed [CW-1:0] cdata;
    logic                 busy;
    logic                 ordy;
    logic signed [DW-1:0] dout;

    modport master (
        output irdy, din, cwe, caddr, cdata,
        input  busy, ordy, dout
    );

    modport slave (
        input  irdy, din, cwe, caddr, cdata,
        output busy, ordy, dout
    );
endinterface

// File: rtl/fir_mac_seq.sv
// Time-multiplexed TAPS-tap FIR: one shared signed multiplier, one accumulator, loadable coefficients.
// Define FIR_SAT_EN to clamp the scaled output; otherwise it wraps to DW bits.
module fir_mac_seq #(
    parameter int DW   = 10,
    parameter int CW   = 12,
    parameter int TAPS = 4,
    parameter int FRAC = 10
) (
    input  logic         clk,
    input  logic         reset,
    fir_mac_seq_if.slave bus
);
    localparam int IW = $clog2(TAPS);
    localparam int PW = DW + CW;
    localparam int AW = PW + IW;

    localparam logic [IW-1:0]        IDX_LAST = IW'(TAPS - 1);
    localparam logic signed [CW-1:0] COEF_ONE = CW'(1 << FRAC);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 w_accept;
    logic                 w_cwr;
    logic [IW-1:0]        r_idx;
    logic signed [AW-1:0] r_acc;
    logic signed [DW-1:0] r_x    [TAPS];
    logic signed [CW-1:0] r_coef [TAPS];
    logic                 r_ordy;
    logic signed [DW-1:0] r_dout;
    logic signed [PW-1:0] w_prod;
    logic signed [DW-1:0] w_scaled;

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_cwr    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cwr = bus.cwe;
                if (bus.irdy) begin
                    w_accept = 1'b1;
                    w_next   = S_MAC;
                end
            end
            S_MAC:   if (r_idx == IDX_LAST) w_next = S_OUT;
            S_OUT:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_prod = r_coef[r_idx] * r_x[r_idx];

`ifdef FIR_SAT_EN
    logic signed [AW-1:0] w_shift;
    always_comb begin
        w_shift = r_acc >>> FRAC;
        if (w_shift > $signed({{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}}))
            w_scaled = {1'b0, {(DW-1){1'b1}}};
        else if (w_shift < $signed({{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}}))
            w_scaled = {1'b1, {(DW-1){1'b0}}};
        else
            w_scaled = w_shift[DW-1:0];
    end
`else
    always_comb w_scaled = DW'(r_acc >>> FRAC);
`endif

    // NOTE: delay line and coefficient bank are flop arrays with defined reset contents, not RAM.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_idx  <= '0;
            r_acc  <= '0;
            r_ordy <= 1'b0;
            r_dout <= '0;
            for (int k = 0; k < TAPS; k++) begin
                r_x[k]    <= '0;
                r_coef[k] <= (k == 0) ? COEF_ONE : '0;
            end
        end else begin
            if (w_cwr && (int'(bus.caddr) < TAPS)) r_coef[bus.caddr] <= bus.cdata;
            case (r_state)
                S_IDLE: if (w_accept) begin
                    for (int k = TAPS - 1; k > 0; k--) r_x[k] <= r_x[k-1];
                    r_x[0] <= bus.din;
                    r_acc  <= '0;
                    r_idx  <= '0;
                    r_ordy <= 1'b0;
                end
                S_MAC: begin
                    r_acc <= r_acc + AW'(w_prod);
                    r_idx <= r_idx + IW'(1);
                end
                S_OUT: begin
                    r_dout <= w_scaled;
                    r_ordy <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (r_state != S_IDLE);
    assign bus.ordy = r_ordy;
    assign bus.dout = r_dout;
endmodule
